// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the ID-stage branch resolution controller.
// Contents: branch type encodings, controller state encodings, and the
// uses_rt helper that tells whether a branch type compares against rt.
package br_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5
  } br_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Only the two-register compares need rt; the zero compares ignore it.
  function automatic logic uses_rt(input logic [2:0] br_type);
    return (br_type == BR_BEQ) || (br_type == BR_BNE);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Bundle between the D stage / forwarding network and the branch resolver.
// master: pipeline side (drives the branch, operands, stall/flush; reads the
//         redirect, stall, error flag and performance counters).
// slave : branch_resolve_ctrl.
interface branch_resolve_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             br_valid;
  logic [2:0]       br_type;
  logic [31:0]      rs_val;
  logic [31:0]      rt_val;
  logic             rs_ready;
  logic             rt_ready;
  logic [31:0]      pc_d;
  logic [15:0]      imm16;
  logic             stall_ext;
  logic             flush_d;
  logic             stall_d;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             wait_timeout;
  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_taken;
  logic [CNT_W-1:0] cnt_stall;

  modport master (
    output br_valid, br_type, rs_val, rt_val, rs_ready, rt_ready,
           pc_d, imm16, stall_ext, flush_d,
    input  stall_d, redirect, redirect_pc, wait_timeout,
           cnt_branch, cnt_taken, cnt_stall
  );

  modport slave (
    input  br_valid, br_type, rs_val, rt_val, rs_ready, rt_ready,
           pc_d, imm16, stall_ext, flush_d,
    output stall_d, redirect, redirect_pc, wait_timeout,
           cnt_branch, cnt_taken, cnt_stall
  );
endinterface

// File: rtl/branch_resolve_ctrl_cmp.sv
// br_cmp: operand comparator for branch resolution.
// Ports: rs, rt (32-bit operands) -> eq (rs == rt), gt_z (signed rs > 0),
//        ge_z (signed rs >= 0).
module br_cmp (
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        eq,
  output logic        gt_z,
  output logic        ge_z
);
  assign eq   = (rs == rt);
  assign ge_z = ~rs[31];
  assign gt_z = ~rs[31] & (|rs);
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage branch resolution for the 5-stage pipeline.
// Waits for forwarded operands, evaluates the branch, drives the PC redirect
// and D-stage stall, holds the outcome while the D stage is frozen, and keeps
// branch / taken / stall performance counters.
// Ports: clk, reset (async, active-low), bus (branch_resolve_ctrl_if.slave).
module branch_resolve_ctrl
  import br_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_ctrl_if.slave  bus
);

  state_e            state, state_n;
  logic              eq, gt_z, ge_z;
  logic              taken, ops_ok;
  logic [31:0]       target;
  logic              hold_taken;
  logic [31:0]       hold_pc;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
  logic              timeout_q;
  logic [CNT_W-1:0]  cnt_branch_q, cnt_taken_q, cnt_stall_q;
  logic              stall, redir, retire, retire_taken, latch_en;
  logic [31:0]       redir_pc;

  br_cmp u_cmp (
    .rs   (bus.rs_val),
    .rt   (bus.rt_val),
    .eq   (eq),
    .gt_z (gt_z),
    .ge_z (ge_z)
  );

  assign ops_ok = bus.rs_ready & (bus.rt_ready | ~uses_rt(bus.br_type));
  assign target = bus.pc_d + 32'd4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};

  always_comb begin
    taken = 1'b0;
    case (bus.br_type)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = ~eq;
      BR_BLEZ: taken = ~gt_z;
      BR_BGTZ: taken = gt_z;
      BR_BLTZ: taken = ~ge_z;
      BR_BGEZ: taken = ge_z;
      default: taken = 1'b0;
    endcase
  end

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_n      = state;
    stall        = 1'b0;
    redir        = 1'b0;
    redir_pc     = target;
    retire       = 1'b0;
    retire_taken = 1'b0;
    latch_en     = 1'b0;
    if (bus.flush_d) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_WAIT: begin
          state_n = ST_IDLE;
          if (bus.br_valid) begin
            if (!ops_ok) begin
              stall   = 1'b1;
              state_n = ST_WAIT;
            end else begin
              redir = taken;
              if (bus.stall_ext) begin
                latch_en = 1'b1;
                state_n  = ST_HOLD;
              end else begin
                retire       = 1'b1;
                retire_taken = taken;
              end
            end
          end
        end
        ST_HOLD: begin
          // Outcome was frozen when the branch resolved; live operands may
          // already belong to younger producers and must not be looked at.
          redir    = hold_taken;
          redir_pc = hold_pc;
          if (!bus.stall_ext) begin
            retire       = 1'b1;
            retire_taken = hold_taken;
            state_n      = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // The counter tracks stall cycles of the current wait episode: the first
  // stall (taken from IDLE) counts as 1, each further WAIT stall adds one.
  always_comb begin
    if (state == ST_WAIT)
      wait_cnt_n = (wait_cnt == {WAIT_W{1'b1}}) ? wait_cnt : wait_cnt + WAIT_W'(1);
    else
      wait_cnt_n = WAIT_W'(1);
  end

  // NOTE: state, latch and counters are all cleared by the asynchronous reset
  // so a branch caught mid-WAIT or mid-HOLD is dropped without being counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      hold_taken   <= 1'b0;
      hold_pc      <= '0;
      wait_cnt     <= '0;
      timeout_q    <= 1'b0;
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
      cnt_stall_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state <= state_n;
      if (latch_en) begin
        hold_taken <= taken;
        hold_pc    <= target;
      end
      if (stall) begin
        wait_cnt <= wait_cnt_n;
        if (wait_cnt_n >= WAIT_W'(MAX_WAIT)) timeout_q <= 1'b1;
      end
      cnt_branch_q <= cnt_branch_q + CNT_W'(retire);
      cnt_taken_q  <= cnt_taken_q + CNT_W'(retire_taken);
      cnt_stall_q  <= cnt_stall_q + CNT_W'(stall);
    end
  end

  // IDLE/WAIT outputs are combinational from the inputs, so they are gated
  // while reset is low.
  assign bus.stall_d      = stall & reset;
  assign bus.redirect     = redir & reset;
  assign bus.redirect_pc  = redir_pc;
  assign bus.wait_timeout = timeout_q;
  assign bus.cnt_branch   = cnt_branch_q;
  assign bus.cnt_taken    = cnt_taken_q;
  assign bus.cnt_stall    = cnt_stall_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural branch model.
module tb_branch_resolve_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.CNT_W(32)) bus ();

  branch_resolve_ctrl #(.MAX_WAIT(4), .WAIT_W(3), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Behavioural model: a pending frozen branch, the length of the current
  // operand wait, the sticky error flag and the three event totals.
  bit          m_hold, m_hold_tk, m_to;
  logic [31:0] m_hold_pc;
  int          m_wait;
  logic [31:0] m_br, m_tk, m_st;

  task automatic model_clear();
    m_hold = 0; m_hold_tk = 0; m_hold_pc = '0; m_wait = 0; m_to = 0;
    m_br = '0; m_tk = '0; m_st = '0;
  endtask

  function automatic bit ref_taken(input int t, input logic [31:0] rs, input logic [31:0] rt);
    int s;
    s = $signed(rs);
    case (t)
      0: return rs == rt;
      1: return rs != rt;
      2: return s <= 0;
      3: return s > 0;
      4: return s < 0;
      5: return s >= 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] imm);
    int off;
    off = int'($signed(imm)) * 4;
    return pc + 32'd4 + 32'(off);
  endfunction

  task automatic drive(input bit v, input int t, input logic [31:0] rs, input logic [31:0] rt,
                       input bit rsr, input bit rtr, input logic [31:0] pc,
                       input logic [15:0] imm, input bit sx, input bit fl);
    bus.br_valid = v;   bus.br_type = 3'(t);
    bus.rs_val = rs;    bus.rt_val = rt;
    bus.rs_ready = rsr; bus.rt_ready = rtr;
    bus.pc_d = pc;      bus.imm16 = imm;
    bus.stall_ext = sx; bus.flush_d = fl;
  endtask

  // One clock: called at a falling edge with inputs driven; checks the DUT
  // against the model, then advances the model across the rising edge.
  task automatic cycle(input string tag);
    bit e_stall, e_redir, retire, rtk, nh, nh_tk, tk;
    logic [31:0] e_pc, nh_pc;
    int nw;
    #1;
    if (!reset) model_clear();
    check({tag, ".cnt_branch"}, bus.cnt_branch, m_br);
    check({tag, ".cnt_taken"}, bus.cnt_taken, m_tk);
    check({tag, ".cnt_stall"}, bus.cnt_stall, m_st);
    check({tag, ".wait_timeout"}, 32'(bus.wait_timeout), 32'(m_to));
    e_stall = 0; e_redir = 0; e_pc = '0; retire = 0; rtk = 0;
    nh = m_hold; nh_tk = m_hold_tk; nh_pc = m_hold_pc; nw = m_wait;
    if (!reset) begin
      nh = 0; nw = 0;
    end else if (bus.flush_d) begin
      nh = 0; nw = 0;
    end else if (m_hold) begin
      e_redir = m_hold_tk; e_pc = m_hold_pc;
      if (!bus.stall_ext) begin retire = 1; rtk = m_hold_tk; nh = 0; end
    end else if (bus.br_valid) begin
      if (!(bus.rs_ready && (bus.rt_ready || bus.br_type >= 2))) begin
        e_stall = 1; nw = m_wait + 1;
      end else begin
        tk = ref_taken(int'(bus.br_type), bus.rs_val, bus.rt_val);
        e_redir = tk; e_pc = ref_target(bus.pc_d, bus.imm16); nw = 0;
        if (bus.stall_ext) begin nh = 1; nh_tk = tk; nh_pc = e_pc; end
        else begin retire = 1; rtk = tk; end
      end
    end else begin
      nw = 0;
    end
    check({tag, ".stall_d"}, 32'(bus.stall_d), 32'(e_stall));
    check({tag, ".redirect"}, 32'(bus.redirect), 32'(e_redir));
    if (e_redir) check({tag, ".redirect_pc"}, bus.redirect_pc, e_pc);
    @(posedge clk);
    if (reset) begin
      m_br += 32'(retire); m_tk += 32'(rtk); m_st += 32'(e_stall);
      m_hold = nh; m_hold_tk = nh_tk; m_hold_pc = nh_pc; m_wait = nw;
      if (nw >= 4) m_to = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(tag);
  endtask

  initial begin
    model_clear();
    reset = 1'b0;
    // Branch presented while reset is low: outputs must stay quiet.
    drive(1, 0, 5, 5, 1, 1, 32'h1000, 16'd3, 0, 0);
    @(negedge clk);
    cycle("rst");
    reset = 1'b1;

    // BEQ taken, same-cycle redirect.
    drive(1, 0, 5, 5, 1, 1, 32'h1000, 16'd3, 0, 0);
    #1 check("beq.redirect_pc", bus.redirect_pc, 32'h0000_1010);
    check("beq.redirect", 32'(bus.redirect), 32'd1);
    cycle("beq");
    idle("beq_idle");
    check("beq.cnt_branch", bus.cnt_branch, 32'd1);
    check("beq.cnt_taken", bus.cnt_taken, 32'd1);

    // BGTZ with the most negative value: not taken.
    drive(1, 3, 32'h8000_0000, 0, 1, 1, 32'h2000, 16'd1, 0, 0);
    cycle("bgtz");
    idle("bgtz_idle");
    check("bgtz.cnt_branch", bus.cnt_branch, 32'd2);
    check("bgtz.cnt_taken", bus.cnt_taken, 32'd1);

    // BNE waiting two cycles on rt.
    drive(1, 1, 1, 2, 1, 0, 32'h2100, 16'd8, 0, 0);
    #1 check("bne.stall_d", 32'(bus.stall_d), 32'd1);
    cycle("bne_w1");
    cycle("bne_w2");
    bus.rt_ready = 1'b1;
    #1 check("bne.redirect", 32'(bus.redirect), 32'd1);
    cycle("bne_go");
    idle("bne_idle");
    check("bne.cnt_stall", bus.cnt_stall, 32'd2);
    check("bne.wait_timeout", 32'(bus.wait_timeout), 32'd0);

    // BLEZ resolved under stall_ext, operands changing while held.
    drive(1, 2, 0, 0, 1, 1, 32'h4000, 16'h0010, 1, 0);
    cycle("blez_res");
    for (int i = 0; i < 2; i++) begin
      bus.rs_val = 32'(5 + i); bus.rs_ready = i[0];
      #1 check("blez.hold_redirect", 32'(bus.redirect), 32'd1);
      cycle("blez_hold");
    end
    bus.stall_ext = 1'b0;
    cycle("blez_rel");
    idle("blez_idle");
    check("blez.cnt_branch", bus.cnt_branch, 32'd4);

    // BGEZ starved of rs for four cycles.
    drive(1, 5, 0, 0, 0, 1, 32'h5000, 16'd2, 0, 0);
    for (int i = 0; i < 4; i++) cycle("to_wait");
    check("to.wait_timeout", 32'(bus.wait_timeout), 32'd1);
    bus.rs_ready = 1'b1;
    cycle("to_go");
    idle("to_idle");
    check("to.sticky", 32'(bus.wait_timeout), 32'd1);

    // Flush while waiting: nothing counted.
    drive(1, 0, 3, 3, 1, 0, 32'h6000, 16'd4, 0, 0);
    cycle("fl_wait");
    bus.flush_d = 1'b1; bus.rt_ready = 1'b1;
    #1 check("fl.redirect", 32'(bus.redirect), 32'd0);
    cycle("fl_flush");
    idle("fl_idle");
    check("fl.cnt_branch", bus.cnt_branch, 32'd5);

    // Reset while holding a branch.
    drive(1, 0, 5, 5, 1, 1, 32'h7000, 16'd4, 1, 0);
    cycle("hr_res");
    reset = 1'b0;
    cycle("hr_rst");
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("hr.redirect", 32'(bus.redirect), 32'd0);
    cycle("hr_after");
    check("hr.cnt_branch", bus.cnt_branch, 32'd0);

    // Negative offset wraps below zero.
    drive(1, 0, 1, 1, 1, 1, 32'h3000, 16'h8000, 0, 0);
    #1 check("wrap.redirect_pc", bus.redirect_pc, 32'hFFFE_3004);
    cycle("wrap");
    idle("wrap_idle");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rs, rt;
      case ($urandom_range(0, 4))
        0: rs = 32'd0;
        1: rs = 32'd1;
        2: rs = 32'hFFFF_FFFF;
        3: rs = 32'h8000_0000;
        default: rs = $urandom;
      endcase
      rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
      reset = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), rs, rt,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            $urandom, 16'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0);
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
